// File: rtl/dla_ingress_pkg.sv
// dla_ingress_pkg: shared types and helpers for the DLA DDR ingress stage
package dla_ingress_pkg;

    typedef enum logic {IDLE, BURST} state_e;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

    function automatic int ch_idx(input int row, input int col, input int num_cols);
        return row * num_cols + col;
    endfunction

endpackage

// File: rtl/dla_ingress_fifo.sv
// dla_ingress_fifo: single-channel synchronous FIFO with occupancy count
module dla_ingress_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // pointer and occupancy updates; push and pop in one cycle leave count unchanged
    always_comb begin
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // control registers, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage array, written only on push
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/dla_ddr_ingress.sv
// dla_ddr_ingress: per-channel DDR FIFOs serialised by a round-robin burst arbiter
module dla_ddr_ingress
    import dla_ingress_pkg::*;
#(
    parameter int NUM_ROWS = 6,
    parameter int NUM_COLS = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH = 8,
    parameter int BURST_LEN = 4,
    localparam int NUM_CH = NUM_ROWS * NUM_COLS,
    localparam int CH_W = clog2_min1(NUM_CH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic [NUM_CH*DATA_W-1:0] i_ddr,
    input  logic [NUM_CH-1:0]        i_ddr_valid,
    output logic [NUM_CH-1:0]        o_ddr_ready,
    output logic [NUM_CH-1:0]        o_dummy_out,
    output logic [DATA_W-1:0]        o_data,
    output logic [CH_W-1:0]          o_ch_id,
    output logic                     o_last,
    output logic                     o_valid,
    input  logic                     i_ready
);

    localparam int BW = clog2_min1(BURST_LEN);

    logic [DATA_W-1:0] head_w [NUM_CH];
    logic [CNT_W-1:0]  count_w [NUM_CH];
    logic [NUM_CH-1:0] push_w, pop_w, dummy_q, dummy_d;
    state_e            state_q, state_d;
    logic [CH_W-1:0]   rr_q, rr_d, grant_q, grant_d, ch_q, ch_d, sel, jc;
    logic [BW-1:0]     beat_q, beat_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d, last_q, last_d;
    logic              found, avail, load_en, pop, last;
    int                j;

    genvar r, c;
    generate
        for (r = 0; r < NUM_ROWS; r++) begin : g_row
            for (c = 0; c < NUM_COLS; c++) begin : g_col
                localparam int C = ch_idx(r, c, NUM_COLS);
                assign o_ddr_ready[C] = (count_w[C] < CNT_W'(DEPTH)) && !i_reset;
                assign push_w[C]      = i_ddr_valid[C] && o_ddr_ready[C];
                assign pop_w[C]       = pop && (sel == CH_W'(C));
                dla_ingress_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
                    .clk  (clk),
                    .rst  (i_reset),
                    .push (push_w[C]),
                    .pop  (pop_w[C]),
                    .din  (i_ddr[C*DATA_W +: DATA_W]),
                    .head (head_w[C]),
                    .count(count_w[C])
                );
            end
        end
    endgenerate

    // channel select: in IDLE the first non-empty channel from rr_q upward, in BURST the grant
    always_comb begin
        sel   = grant_q;
        found = 1'b0;
        j     = 0;
        jc    = '0;
        if (state_q == IDLE) begin
            for (int k = 0; k < NUM_CH; k++) begin
                j = int'(rr_q) + k;
                if (j >= NUM_CH) j = j - NUM_CH;
                jc = CH_W'(j);
                if (!found && count_w[jc] != '0) begin
                    sel   = jc;
                    found = 1'b1;
                end
            end
        end
    end

    assign avail   = count_w[sel] != '0;
    assign load_en = !valid_q || i_ready;
    assign pop     = load_en && avail;
    assign last    = (beat_q == BW'(BURST_LEN - 1)) || (count_w[sel] == CNT_W'(1));

    // arbiter next state and output register load; a stalled output freezes everything
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        data_d  = data_q;
        ch_d    = ch_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (pop) begin
            data_d  = head_w[sel];
            ch_d    = sel;
            last_d  = last;
            valid_d = 1'b1;
            grant_d = sel;
            state_d = last ? IDLE : BURST;
            beat_d  = last ? '0 : beat_q + BW'(1);
            rr_d    = !last ? rr_q : (sel == CH_W'(NUM_CH - 1)) ? '0 : sel + CH_W'(1);
        end else if (i_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    // parity of the most recent word accepted on each channel
    always_comb begin
        dummy_d = dummy_q;
        for (int k = 0; k < NUM_CH; k++)
            if (push_w[k]) dummy_d[k] = ^i_ddr[k*DATA_W +: DATA_W];
    end

    // state registers; reset drops any in-flight beat
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            rr_q    <= '0;
            grant_q <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            dummy_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            dummy_q <= dummy_d;
        end
    end

    assign o_data      = data_q;
    assign o_ch_id     = ch_q;
    assign o_last      = last_q;
    assign o_valid     = valid_q;
    assign o_dummy_out = dummy_q;

endmodule

// File: tb/tb_dla_ddr_ingress.sv
// tb_dla_ddr_ingress: directed scoreboard bench for dla_ddr_ingress
module tb_dla_ddr_ingress;

    localparam int NCH = 24;
    localparam int DW = 16;
    localparam int CW = 5;

    typedef logic [DW+CW:0] exp_t;

    logic                clk = 1'b0;
    logic                i_reset;
    logic [NCH*DW-1:0]   i_ddr;
    logic [NCH-1:0]      i_ddr_valid, o_ddr_ready, o_dummy_out;
    logic [DW-1:0]       o_data;
    logic [CW-1:0]       o_ch_id;
    logic                o_last, o_valid, i_ready;
    exp_t                q[$];
    int                  errors = 0;
    int                  checks = 0;

    always #5 clk = ~clk;

    dla_ddr_ingress #(
        .NUM_ROWS(6), .NUM_COLS(4), .DATA_W(DW), .DEPTH(8), .BURST_LEN(4)
    ) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_ddr      (i_ddr),
        .i_ddr_valid(i_ddr_valid),
        .o_ddr_ready(o_ddr_ready),
        .o_dummy_out(o_dummy_out),
        .o_data     (o_data),
        .o_ch_id    (o_ch_id),
        .o_last     (o_last),
        .o_valid    (o_valid),
        .i_ready    (i_ready)
    );

    function automatic exp_t ex(input logic [DW-1:0] d, input int ch, input logic l);
        return {d, CW'(ch), l};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // one cycle: score any handshake about to happen, then advance to the next falling edge
    task automatic cyc();
        exp_t e;
        if (o_valid && i_ready) begin
            e = 'x;
            if (q.size() > 0) e = q.pop_front();
            chk("out", {o_data, o_ch_id, o_last}, e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input int c, input logic [DW-1:0] w);
        i_ddr[c*DW +: DW] = w;
        i_ddr_valid[c] = 1'b1;
        for (int k = 0; k < 50 && !o_ddr_ready[c]; k++) cyc();
        chk("push_ready", o_ddr_ready[c], 1);
        cyc();
        i_ddr_valid[c] = 1'b0;
    endtask

    task automatic push2(input int c1, input logic [DW-1:0] w1, input int c2, input logic [DW-1:0] w2);
        i_ddr[c1*DW +: DW] = w1;
        i_ddr[c2*DW +: DW] = w2;
        i_ddr_valid[c1] = 1'b1;
        i_ddr_valid[c2] = 1'b1;
        chk("push2_ready", {o_ddr_ready[c1], o_ddr_ready[c2]}, 2'b11);
        cyc();
        i_ddr_valid[c1] = 1'b0;
        i_ddr_valid[c2] = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && (q.size() > 0 || o_valid); k++) cyc();
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        i_reset = 1'b1;
        i_ddr = '0;
        i_ddr_valid = '0;
        i_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", o_ddr_ready, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ch", o_ch_id, 0);
        chk("rst_dummy", o_dummy_out, 0);
        i_reset = 1'b0;
        #1;
        chk("ready_all", o_ddr_ready, {NCH{1'b1}});

        // single word, two-cycle latency
        q.push_back(ex(16'h00FF, 5, 1'b1));
        push(5, 16'h00FF);
        chk("lat1", o_valid, 0);
        cyc();
        chk("lat2", o_valid, 1);
        chk("dummy5", o_dummy_out[5], 0);
        drain();

        // burst cap with an interleaved channel, preceded by a stalled word on ch 3
        i_ready = 1'b0;
        q.push_back(ex(16'h0333, 3, 1'b1));
        for (int i = 1; i <= 4; i++) q.push_back(ex(DW'(i), 0, i == 4));
        q.push_back(ex(16'hAAAA, 1, 1'b1));
        q.push_back(ex(16'h0005, 0, 1'b0));
        q.push_back(ex(16'h0006, 0, 1'b1));
        push(3, 16'h0333);
        for (int i = 1; i <= 6; i++) push(0, DW'(i));
        push(1, 16'hAAAA);
        i_ready = 1'b1;
        repeat (3) cyc();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall", {o_data, o_ch_id, o_last, o_valid}, {q[0], 1'b1});
            cyc();
        end
        i_ready = 1'b1;
        drain();

        // fill ch 23 to full behind a stalled word, ninth word waits for the first pop
        i_ready = 1'b0;
        q.push_back(ex(16'h0A0A, 10, 1'b1));
        for (int i = 1; i <= 9; i++) q.push_back(ex(16'h2300 + DW'(i), 23, i == 4 || i == 8 || i == 9));
        push(10, 16'h0A0A);
        for (int i = 1; i <= 8; i++) push(23, 16'h2300 + DW'(i));
        chk("full_ready", o_ddr_ready[23], 0);
        i_ddr[23*DW +: DW] = 16'h2309;
        i_ddr_valid[23] = 1'b1;
        repeat (2) begin
            cyc();
            chk("full_hold", o_ddr_ready[23], 0);
        end
        i_ready = 1'b1;
        push(23, 16'h2309);
        chk("dummy23", o_dummy_out[23], ^16'h2309);
        drain();

        // round-robin wrap: move rr_ptr to 23, then ch 23 and ch 2 arrive together
        q.push_back(ex(16'h2222, 22, 1'b1));
        push(22, 16'h2222);
        drain();
        q.push_back(ex(16'h2323, 23, 1'b1));
        q.push_back(ex(16'h0202, 2, 1'b1));
        push2(2, 16'h0202, 23, 16'h2323);
        drain();

        // reset in the middle of a 4-beat burst
        i_ready = 1'b0;
        q.push_back(ex(16'h0909, 9, 1'b1));
        for (int i = 1; i <= 4; i++) q.push_back(ex(16'h7000 + DW'(i), 7, i == 4));
        push(9, 16'h0909);
        for (int i = 1; i <= 4; i++) push(7, 16'h7000 + DW'(i));
        i_ready = 1'b1;
        repeat (2) cyc();
        i_ready = 1'b0;
        i_reset = 1'b1;
        #1;
        chk("midrst_ready", o_ddr_ready, 0);
        cyc();
        i_reset = 1'b0;
        #1;
        chk("post_valid", o_valid, 0);
        chk("post_ready", o_ddr_ready, {NCH{1'b1}});
        chk("post_dummy", o_dummy_out, 0);
        q.delete();
        i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stale", o_valid, 0);
            cyc();
        end

        // rr_ptr is back at 0 after reset: ch 5 wins over ch 20
        q.push_back(ex(16'h0505, 5, 1'b1));
        q.push_back(ex(16'h2020, 20, 1'b1));
        push2(20, 16'h2020, 5, 16'h0505);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
